// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its consumers:
// FSM states, key code constants and the row/column decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [3:0] ROW_FIRST = 4'b1110;
    localparam logic [3:0] COLS_IDLE = 4'b1111;

    // Physical layout: row 0 is the top row "1 2 3 A", column 0 the left column.
    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic one_low(input logic [3:0] v);
        return $countones(~v) == 1;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        tick_o  = (count_q == LAST);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold row drive, debounces the
// synchronised columns and emits one key_press strobe per physical press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_press,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int DBC_W = $clog2(DEBOUNCE_SCANS + 1) + 1;
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_SCANS);

    logic tick;

    logic [3:0]       cs_meta_q;
    logic [3:0]       cs_q;
    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       col_q, col_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;
    logic [DBC_W-1:0] dbc_inc;
    logic [3:0]       row_rot;
    logic             key_press_q, key_press_d;
    logic [3:0]       key_code_q, key_code_d;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i  (CLOCK_50),
        .reset_i(reset),
        .tick_o (tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cs_meta_q   <= COLS_IDLE;
            cs_q        <= COLS_IDLE;
            state_q     <= SCAN;
            row_q       <= ROW_FIRST;
            col_q       <= COLS_IDLE;
            dbc_q       <= '0;
            key_press_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            cs_meta_q   <= col_n;
            cs_q        <= cs_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dbc_q       <= dbc_d;
            key_press_q <= key_press_d;
            key_code_q  <= key_code_d;
        end
    end

    // The row is frozen outside SCAN so the debounced column stays tied to one row.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        dbc_d       = dbc_q;
        key_press_d = 1'b0;
        key_code_d  = key_code_q;
        dbc_inc     = dbc_q + 1'b1;
        row_rot     = {row_q[2:0], row_q[3]};

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_low(cs_q)) begin
                        col_d   = cs_q;
                        dbc_d   = DBC_W'(1);
                        state_d = PRESS_DB;
                    end else begin
                        row_d = row_rot;
                    end
                end
                PRESS_DB: begin
                    if (cs_q == col_q) begin
                        if (dbc_inc >= DBC_LAST) begin
                            state_d     = HELD;
                            dbc_d       = '0;
                            key_press_d = 1'b1;
                            key_code_d  = key_decode(low_index(row_q), low_index(col_q));
                        end else begin
                            dbc_d = dbc_inc;
                        end
                    end else begin
                        dbc_d   = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (cs_q == COLS_IDLE) begin
                        dbc_d   = DBC_W'(1);
                        state_d = REL_DB;
                    end
                end
                REL_DB: begin
                    if (cs_q == COLS_IDLE) begin
                        if (dbc_inc >= DBC_LAST) begin
                            dbc_d   = '0;
                            row_d   = row_rot;
                            state_d = SCAN;
                        end else begin
                            dbc_d = dbc_inc;
                        end
                    end else begin
                        // A bounce back to contact resumes the hold without a new strobe.
                        dbc_d   = '0;
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_comb begin
        row_n     = row_q;
        key_press = key_press_q;
        key_code  = key_code_q;
        key_held  = (state_q == HELD) || (state_q == REL_DB);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model shorts row r onto column c
// for every pressed key; strobes are counted and codes checked against the map.
module tb_keypad_scanner;

    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_press;
    logic [3:0]  key_code;
    logic        key_held;

    logic [15:0] pressed = '0;
    int          checks = 0;
    int          passes = 0;
    int          strobes = 0;
    int          base;
    logic [3:0]  prev;
    logic [3:0]  exp_map [16];
    bit          press_pat [5];
    bit          rel_pat [5];

    always #5 clk = ~clk;

    keypad_scanner #(
        .TICK_DIV      (TICK_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_press(key_press),
        .key_code (key_code),
        .key_held (key_held)
    );

    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_n[r]) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_press) begin
            strobes <= strobes + 1;
            $display("strobe: key_code=%0d", key_code);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    task automatic wait_press(input string tag, input int from);
        int n;
        n = 0;
        while (strobes == from && n < 200) begin
            step();
            n++;
        end
        check(tag, (strobes != from) ? 1 : 0, 1);
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (key_held && n < 200) begin
            step();
            n++;
        end
        check(tag, key_held, 0);
    endtask

    // Returns just after the tick edge on which row_n switched to target.
    task automatic wait_row(input logic [3:0] target);
        logic [3:0] last;
        int n;
        n = 0;
        last = row_n;
        step();
        while (!(row_n == target && last != target) && n < 100) begin
            last = row_n;
            step();
            n++;
        end
        check("row_align", row_n, target);
    endtask

    initial begin
        exp_map   = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                      4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};
        press_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        rel_pat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        steps(3);
        check("rst_row", row_n, 4'b1110);
        check("rst_press", key_press, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        reset = 1'b0;

        // '5': row 1, column 1, held for well over ten ticks
        base = strobes;
        pressed[5] = 1'b1;
        wait_press("p5_seen", base);
        steps(40);
        check("p5_strobes", strobes - base, 1);
        check("p5_code", key_code, 5);
        check("p5_held", key_held, 1);
        pressed = '0;
        steps(8);
        check("r5_not_early", key_held, 1);
        wait_release("r5_drop");
        check("r5_row", row_n, 4'b1011);

        // bouncy '#' aligned to the ticks that scan row 3
        wait_row(4'b0111);
        base = strobes;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("bp_no_early", strobes - base, 0);
            pressed[14] = press_pat[i];
            steps(4);
        end
        check("bp_press", key_press, 1);
        check("bp_code", key_code, 15);
        for (int i = 0; i < 5; i++) begin
            pressed[14] = rel_pat[i];
            steps(4);
            if (i == 3) check("br_still_held", key_held, 1);
        end
        check("br_drop", key_held, 0);
        check("br_row", row_n, 4'b1110);
        check("br_strobes", strobes - base, 1);

        // ghost: '1' and '2' together
        base = strobes;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        steps(60);
        check("ghost_strobes", strobes - base, 0);
        check("ghost_held", key_held, 0);
        for (int i = 0; i < 2; i++) begin
            prev = row_n;
            steps(4);
            check("ghost_rot", row_n, {prev[2:0], prev[3]});
        end
        pressed = '0;
        steps(8);

        // '4' held, then '9' in another row
        base = strobes;
        pressed[4] = 1'b1;
        wait_press("two_4_seen", base);
        check("two_4_code", key_code, 4);
        pressed[10] = 1'b1;
        steps(48);
        check("two_9_hidden", strobes - base, 1);
        check("two_code_kept", key_code, 4);
        pressed[4] = 1'b0;
        wait_press("two_9_seen", base + 1);
        check("two_9_code", key_code, 9);
        check("two_strobes", strobes - base, 2);
        pressed = '0;
        wait_release("two_drop");

        // sweep of all 16 keys
        base = strobes;
        for (int k = 0; k < 16; k++) begin
            pressed[k] = 1'b1;
            wait_press($sformatf("sweep_seen_%0d", k), strobes);
            check($sformatf("sweep_code_%0d", k), key_code, exp_map[k]);
            pressed[k] = 1'b0;
            wait_release($sformatf("sweep_rel_%0d", k));
        end
        check("sweep_strobes", strobes - base, 16);

        // reset while a key is held
        base = strobes;
        pressed[15] = 1'b1;
        wait_press("rh_seen", base);
        steps(4);
        check("rh_held_before", key_held, 1);
        reset = 1'b1;
        step();
        check("rh_row", row_n, 4'b1110);
        check("rh_held", key_held, 0);
        check("rh_press", key_press, 0);
        check("rh_code", key_code, 0);
        reset = 1'b0;
        pressed = '0;
        steps(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
